// File: rtl/mem_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_stage_pkg                                                            |
// | Shared types and width helpers for the cached MEM-stage block.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mem_stage_pkg;

  // Controller states: IDLE serves hits, FILL/WRITE run SRAM beats,
  // RESP is the single unfrozen cycle that hands a result to the pipeline.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Bit width needed to index v items, never less than one bit so that
  // degenerate configurations still produce legal vectors.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  // Number of SRAM beats that make up one CPU word.
  function automatic int beats_of(input int data_w, input int dq_w);
    return data_w / dq_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_cached_sram_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_seq                                                                 |
// | Runs a burst of SRAM beats, each held for WAIT cycles, and owns the      |
// | SRAM pins and data-bus tristate.                                         |
// | Ports: clk, rst (async, active-low), req (burst active), wr (write       |
// |   burst), last_beat (index of final beat), base_addr, wdata (write word),|
// |   done (pulse on final cycle), rd_data (assembled read beats), SRAM_*.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sram_seq
  import mem_stage_pkg::*;
#(
  parameter int DQ_W      = 16,
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 4,
  parameter int WAIT      = 5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req,
  input  logic                                 wr,
  input  logic [clog2_min1(MAX_BEATS)-1:0]     last_beat,
  input  logic [ADDR_W-1:0]                    base_addr,
  input  logic [DATA_W-1:0]                    wdata,
  output logic                                 done,
  output logic [MAX_BEATS*DQ_W-1:0]            rd_data,
  inout  wire  [DQ_W-1:0]                      SRAM_DQ,
  output logic [ADDR_W-1:0]                    SRAM_ADDR,
  output logic                                 SRAM_UB_N,
  output logic                                 SRAM_LB_N,
  output logic                                 SRAM_WE_N,
  output logic                                 SRAM_CE_N,
  output logic                                 SRAM_OE_N
);

  localparam int c_BEAT_W = clog2_min1(MAX_BEATS);
  localparam int c_WAIT_W = clog2_min1(WAIT);

  logic [c_BEAT_W-1:0] r_beat;
  logic [c_WAIT_W-1:0] r_wait;
  logic [DQ_W-1:0]     r_buf [MAX_BEATS];
  logic                w_beat_end;
  logic                w_sample;
  logic [DQ_W-1:0]     w_wbeat;

  assign w_beat_end = (r_wait == c_WAIT_W'(WAIT - 1));
  assign w_sample   = req & ~wr & w_beat_end;
  assign done       = req & w_beat_end & (r_beat == last_beat);
  assign w_wbeat    = DQ_W'(wdata >> (DQ_W * r_beat));

  // Counters idle at zero whenever no burst is requested, so the first
  // beat starts in the same cycle the request appears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat <= '0;
      r_wait <= '0;
    end else if (!req) begin
      r_beat <= '0;
      r_wait <= '0;
    end else if (w_beat_end) begin
      r_wait <= '0;
      r_beat <= done ? '0 : r_beat + c_BEAT_W'(1);
    end else begin
      r_wait <= r_wait + c_WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_sample) r_buf[r_beat] <= SRAM_DQ;
  end

  // The beat being sampled right now bypasses the buffer so the whole line
  // is available on the done cycle.
  for (genvar b = 0; b < MAX_BEATS; b++) begin : g_rd
    assign rd_data[b*DQ_W +: DQ_W] =
      (w_sample && (r_beat == c_BEAT_W'(b))) ? SRAM_DQ : r_buf[b];
  end

  assign SRAM_ADDR = req ? (base_addr + ADDR_W'(r_beat)) : '0;
  assign SRAM_WE_N = ~(req & wr);
  assign SRAM_OE_N = ~(req & ~wr);
  assign SRAM_DQ   = (req & wr) ? w_wbeat : {DQ_W{1'bz}};
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;

endmodule
`default_nettype wire

// File: rtl/mem_stage_cached.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_stage_cached                                                         |
// | 2-way set-associative, write-through, no-write-allocate cache in front   |
// | of an asynchronous narrow-bus SRAM, with per-set LRU and hit/miss stats. |
// | Ports: clk, rst (async, active-low), mem_r_en/mem_w_en (requests held   |
// |   while frozen), address, wdata, rdata, freeze (pipeline stall),         |
// |   hit_count/miss_count (saturating), SRAM_* (external SRAM interface).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_stage_cached
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SRAM_DQ_W   = 16,
  parameter int SRAM_ADDR_W = 18,
  parameter int ADDR_BASE   = 1024,
  parameter int SETS        = 64,
  parameter int LINE_WORDS  = 2,
  parameter int SRAM_WAIT   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [31:0]            address,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   freeze,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count,
  inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N
);

  localparam int c_BEATS      = beats_of(DATA_W, SRAM_DQ_W);
  localparam int c_LINE_BEATS = LINE_WORDS * c_BEATS;
  localparam int c_BEAT_W     = clog2_min1(c_LINE_BEATS);
  localparam int c_OFF_SH     = $clog2(LINE_WORDS);
  localparam int c_IDX_SH     = $clog2(SETS);
  localparam int c_OFF_W      = clog2_min1(LINE_WORDS);
  localparam int c_IDX_W      = clog2_min1(SETS);
  localparam int c_TAG_W      = 30 - c_OFF_SH - c_IDX_SH;

  // Address decode.
  logic [29:0]        w_wa;
  logic [29:0]        w_line_wa;
  logic [c_OFF_W-1:0] w_off;
  logic [c_IDX_W-1:0] w_idx;
  logic [c_TAG_W-1:0] w_tag;

  assign w_wa      = 30'((address - 32'(ADDR_BASE)) >> 2);
  assign w_line_wa = w_wa & ~30'(LINE_WORDS - 1);
  assign w_off     = c_OFF_W'(w_wa & 30'(LINE_WORDS - 1));
  assign w_idx     = c_IDX_W'((w_wa >> c_OFF_SH) & 30'(SETS - 1));
  assign w_tag     = c_TAG_W'(w_wa >> (c_OFF_SH + c_IDX_SH));

  // Cache storage.
  logic [1:0][SETS-1:0] r_valid;
  logic [SETS-1:0]      r_lru;
  logic [c_TAG_W-1:0]   r_tag  [2][SETS];
  logic [DATA_W-1:0]    r_data [2][SETS][LINE_WORDS];
  logic [15:0]          r_hit_cnt;
  logic [15:0]          r_miss_cnt;
  state_t               r_state;
  state_t               w_state_nxt;

  logic w_hit0, w_hit1, w_hit, w_hit_way, w_victim;
  logic [DATA_W-1:0] w_hit_word;

  assign w_hit0     = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
  assign w_hit1     = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
  assign w_hit      = w_hit0 | w_hit1;
  assign w_hit_way  = w_hit1;
  assign w_hit_word = r_data[w_hit_way][w_idx][w_off];
  assign w_victim   = r_lru[w_idx];

  // Sequencer interface.
  logic                          w_seq_req;
  logic                          w_seq_done;
  logic [c_LINE_BEATS*SRAM_DQ_W-1:0] w_seq_rd;
  logic [SRAM_ADDR_W-1:0]        w_seq_base;
  logic [c_BEAT_W-1:0]           w_seq_last;
  logic                          w_freeze;
  logic                          w_rd_hit;
  logic                          w_rd_miss;
  logic [DATA_W-1:0]             w_rdata;

  // Stores use the exact word; fills start at the line base.
  assign w_seq_base = mem_w_en ? SRAM_ADDR_W'(w_wa * c_BEATS)
                               : SRAM_ADDR_W'(w_line_wa * c_BEATS);
  assign w_seq_last = mem_w_en ? c_BEAT_W'(c_BEATS - 1)
                               : c_BEAT_W'(c_LINE_BEATS - 1);
  // Gating with rst keeps the pins and stall quiet while reset is held,
  // even if the pipeline keeps presenting a request.
  assign w_seq_req  = w_freeze & rst;

  always_comb begin
    w_state_nxt = r_state;
    w_freeze    = 1'b0;
    w_rdata     = '0;
    w_rd_hit    = 1'b0;
    w_rd_miss   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_w_en) begin
          w_freeze    = 1'b1;
          w_state_nxt = S_WRITE;
        end else if (mem_r_en) begin
          if (w_hit) begin
            w_rdata  = w_hit_word;
            w_rd_hit = 1'b1;
          end else begin
            w_freeze    = 1'b1;
            w_rd_miss   = 1'b1;
            w_state_nxt = S_FILL;
          end
        end
      end
      S_FILL, S_WRITE: begin
        w_freeze = 1'b1;
        if (w_seq_done) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
        if (mem_r_en && !mem_w_en) w_rdata = DATA_W'(w_seq_rd >> (DATA_W * w_off));
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_lru      <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_rd_hit) begin
        r_lru[w_idx] <= ~w_hit_way;
        if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
      end
      if (w_rd_miss && (r_miss_cnt != 16'hFFFF)) r_miss_cnt <= r_miss_cnt + 16'd1;
      if ((r_state == S_FILL) && w_seq_done) begin
        r_valid[w_victim][w_idx] <= 1'b1;
        r_lru[w_idx]             <= ~w_victim;
      end
      if ((r_state == S_WRITE) && w_seq_done && w_hit) r_lru[w_idx] <= ~w_hit_way;
    end
  end

  // Tags and data need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if ((r_state == S_FILL) && w_seq_done) begin
      r_tag[w_victim][w_idx] <= w_tag;
      for (int w = 0; w < LINE_WORDS; w++) begin
        r_data[w_victim][w_idx][w] <= w_seq_rd[w*DATA_W +: DATA_W];
      end
    end
    if ((r_state == S_WRITE) && w_seq_done && w_hit) begin
      r_data[w_hit_way][w_idx][w_off] <= wdata;
    end
  end

  sram_seq #(
    .DQ_W      (SRAM_DQ_W),
    .ADDR_W    (SRAM_ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_BEATS (c_LINE_BEATS),
    .WAIT      (SRAM_WAIT)
  ) u_sram_seq (
    .clk       (clk),
    .rst       (rst),
    .req       (w_seq_req),
    .wr        (mem_w_en),
    .last_beat (w_seq_last),
    .base_addr (w_seq_base),
    .wdata     (wdata),
    .done      (w_seq_done),
    .rd_data   (w_seq_rd),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_OE_N (SRAM_OE_N)
  );

  assign freeze     = w_freeze & rst;
  assign rdata      = rst ? w_rdata : '0;
  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

endmodule
`default_nettype wire

// File: doc/mem_stage_cached.md
Name: mem_stage_cached

Overview:
- Parametrised MEM-stage memory block: 2-way set-associative, write-through, no-write-allocate cache in front of an off-chip asynchronous SRAM with a narrow data bus.
- Generalises the previous fixed-width cache controller in four ways:
  - configurable data and SRAM widths, set count and line length;
  - configurable SRAM wait states;
  - per-set LRU replacement;
  - hit/miss statistics counters.
- Drives freeze to stall the pipeline (IF/ID/EX registers held) while an SRAM transaction is outstanding.

Parameters:
- DATA_W, 32, CPU word width; must be a multiple of SRAM_DQ_W.
- SRAM_DQ_W, 16, SRAM data bus width. BEATS = DATA_W/SRAM_DQ_W.
- SRAM_ADDR_W, 18, SRAM address width.
- ADDR_BASE, 1024, byte offset subtracted from the CPU address before mapping.
- SETS, 64, cache sets; power of two.
- LINE_WORDS, 2, words per line; power of two.
- SRAM_WAIT, 5, clock cycles each SRAM beat is held; minimum 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- mem_r_en  in  1  load request, held stable while freeze=1.
- mem_w_en  in  1  store request, held stable while freeze=1.
- address  in  32  CPU byte address, word aligned.
- wdata  in  DATA_W  store data.
- rdata  out  DATA_W  load result.
- freeze  out  1  stall request to the pipeline.
- hit_count  out  16  saturating count of read hits.
- miss_count  out  16  saturating count of read misses.
- SRAM_DQ  inout  SRAM_DQ_W  SRAM data bus.
- SRAM_ADDR  out  SRAM_ADDR_W  SRAM address.
- SRAM_UB_N  out  1  upper byte enable; tied 0.
- SRAM_LB_N  out  1  lower byte enable; tied 0.
- SRAM_WE_N  out  1  SRAM write enable.
- SRAM_CE_N  out  1  SRAM chip enable; tied 0.
- SRAM_OE_N  out  1  SRAM output enable.

Behaviour:
- Address mapping:
  - word address wa = (address - ADDR_BASE) >> 2.
  - offset = wa[log2(LINE_WORDS)-1:0]; index = next log2(SETS) bits; tag = remaining bits.
  - SRAM beat address = wa*BEATS + beat, truncated to SRAM_ADDR_W.
  - Beat 0 carries bits [SRAM_DQ_W-1:0], low half first.
- Storage, per set: 2 ways × (valid, tag, LINE_WORDS data words) plus 1 LRU bit, where LRU points at the victim way.
- FSM states: IDLE, FILL, WRITE, RESP.
- IDLE:
  - Read hit: rdata = hit word combinationally in the same cycle; freeze=0; LRU set to the other way; hit_count++.
  - Read miss: freeze=1 combinationally; go to FILL; miss_count++ on entry.
  - Write: freeze=1; go to WRITE.
  - mem_r_en and mem_w_en both high: treated as a write.
- FILL:
  - Read LINE_WORDS*BEATS beats starting at line base.
  - Each beat holds SRAM_ADDR with OE_N=0, WE_N=1 for SRAM_WAIT cycles; DQ is sampled on the last cycle of the beat.
  - Afterwards write the whole line into way LRU, set valid and tag, set LRU to the other way, then go to RESP.
- WRITE:
  - Drive BEATS beats of wdata, each with WE_N=0, OE_N=1 and DQ driven for SRAM_WAIT cycles.
  - On a write hit, update the cached word at the last beat and point LRU away from the hit way.
  - A write miss does not allocate.
  - Go to RESP.
- RESP:
  - One cycle with freeze=0.
  - rdata = requested word for a load; 0 for a store.
  - Return to IDLE. The pipeline advances on this cycle.
- freeze: high from the request cycle through the last FILL/WRITE cycle. Read-miss stall = LINE_WORDS*BEATS*SRAM_WAIT cycles (20 at defaults); write stall = BEATS*SRAM_WAIT cycles (10 at defaults).
- SRAM idle levels: WE_N=1, OE_N=1, SRAM_DQ high-Z. DQ is driven only while WE_N=0.
- rdata is 0 when there is no read hit and the state is not RESP.
- hit_count and miss_count saturate at 16'hFFFF. Stores do not count.
- Reset (rst=0), asynchronous, applies at any time including mid-FILL/WRITE:
  - state=IDLE, all valid and LRU bits 0, counters 0;
  - freeze=0, rdata=0, WE_N=1, OE_N=1, DQ high-Z, SRAM_ADDR=0;
  - partially filled lines are discarded.

Decomposition:
- Package mem_stage_pkg:
  - state enum (IDLE, FILL, WRITE, RESP);
  - clog2-derived localparam helpers for offset/index/tag widths and BEATS.
- Sub-module sram_seq:
  - runs N beats of SRAM_WAIT cycles each;
  - owns the beat and wait counters, SRAM pins and DQ tristate;
  - returns assembled read words and a done pulse.
- The cache arrays and FSM live in the top module.

Test Plan:
- Cold read, address=1024, SRAM words 0/1 preloaded 0x1111/0x2222 -> freeze high 20 cycles, then RESP with rdata=0x22221111; miss_count=1.
- Repeat read at 1024, then read 1028 -> each returns in the request cycle with freeze=0 (1028 is the same line); hit_count=2.
- Store 0xDEADBEEF to 1024 (hit) -> 10-cycle freeze with beats 0xBEEF then 0xDEAD on SRAM_ADDR 0,1; next read hits with 0xDEADBEEF. Store to an uncached address -> no allocate, next read misses.
- Three reads mapping to the same set with distinct tags A, B, C (A read again before C) -> C evicts B; a following read of A hits and a following read of B misses.
- Assert rst=0 at cycle 7 of a FILL -> outputs go to reset values immediately; after release, a read of the same address misses again and completes correctly.
- Reads, then counters held at 0xFFFE plus 3 read hits -> hit_count stays 0xFFFF.
